// File: rtl/fsm_serialdata_tx.sv
// fsm_serialdata_tx
// Serial byte transmitter for single-wire async framing.
// The line idles high. Each frame is one start bit (0), then 8 data bits
// sent LSB first, then optionally a parity bit, then STOP_BITS stop bits (1).
// Bytes are accepted on a valid/ready handshake. The line output is registered.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles each bit is held on the line (>= 1)
//   STOP_BITS     stop bits per frame (1 or 2)
//   ODD_PARITY    parity sense when parity is compiled in (0 = even, 1 = odd)
//
// Compile-time option:
//   FSM_SERIALDATA_TX_PARITY_EN  when defined, a parity bit follows D7.
//   When it is not defined, D7 goes straight to the stop bit(s).
//
// Ports:
//   clk         clock; all logic runs on posedge
//   reset       synchronous, active-high reset
//   in_byte_i   byte to send; it is sampled only when accepted
//   in_valid_i  the producer has a byte
//   in_ready_o  the transmitter can accept a byte this cycle
//   out_o       serial line; registered, idle high
//   busy_o      a frame is in progress
//   done_o      one-cycle pulse while the final stop bit is on the line
//
// State table:
//   state    | meaning
//   S_IDLE   | line high, waiting for a byte
//   S_START  | start bit (0) on the line
//   S_DATA   | data bit shift_q[0] on the line; bit_cnt_q selects D0..D7
//   S_PARITY | parity bit on the line (parity builds only)
//   S_STOP   | stop bit (1) on the line; bit_cnt_q counts the stop bits
module fsm_serialdata_tx #(
    parameter int CLKS_PER_BIT = 1,
    parameter int STOP_BITS    = 1,
    parameter int ODD_PARITY   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_byte_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    output logic       out_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int              CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]   CLK_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 1 || STOP_BITS < 1 || STOP_BITS > 2 ||
        ODD_PARITY < 0 || ODD_PARITY > 1) begin : g_bad_param
        $error("fsm_serialdata_tx: illegal parameter value");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            out_q, out_d;
`ifdef FSM_SERIALDATA_TX_PARITY_EN
    logic            parity_q, parity_d;
`endif

    logic last_clk, last_stop, accept;

    assign last_clk  = (clk_cnt_q == CLK_LAST);
    assign last_stop = (bit_cnt_q == STOP_LAST);
    assign accept    = in_valid_i && in_ready_o;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            out_q     <= 1'b1;
`ifdef FSM_SERIALDATA_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            out_q     <= out_d;
`ifdef FSM_SERIALDATA_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
`ifdef FSM_SERIALDATA_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        if (state_q != S_IDLE) begin
            clk_cnt_d = last_clk ? '0 : clk_cnt_q + CW'(1);
        end
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_START;
                    shift_d   = in_byte_i;
                    bit_cnt_d = '0;
                    clk_cnt_d = '0;
`ifdef FSM_SERIALDATA_TX_PARITY_EN
                    parity_d  = ^in_byte_i;
`endif
                end
            end
            S_START: begin
                if (last_clk) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (last_clk) begin
                    // The next data bit is presented as shift_d[0].
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = '0;
`ifdef FSM_SERIALDATA_TX_PARITY_EN
                        state_d   = S_PARITY;
`else
                        state_d   = S_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
`ifdef FSM_SERIALDATA_TX_PARITY_EN
            S_PARITY: begin
                if (last_clk) begin
                    state_d   = S_STOP;
                    bit_cnt_d = '0;
                end
            end
`endif
            S_STOP: begin
                if (last_clk) begin
                    if (last_stop) begin
                        bit_cnt_d = '0;
                        if (accept) begin
                            // Accept in the final stop cycle: the next frame
                            // starts with no idle gap.
                            state_d   = S_START;
                            shift_d   = in_byte_i;
`ifdef FSM_SERIALDATA_TX_PARITY_EN
                            parity_d  = ^in_byte_i;
`endif
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d   = S_IDLE;
                clk_cnt_d = '0;
                bit_cnt_d = '0;
            end
        endcase
    end

    // The line value is taken from the next state, so the registered output
    // stays aligned with state_q.
    always_comb begin
        busy_o     = (state_q != S_IDLE);
        done_o     = (state_q == S_STOP) && last_stop && last_clk;
        in_ready_o = (state_q == S_IDLE) || done_o;
        case (state_d)
            S_START:  out_d = 1'b0;
            S_DATA:   out_d = shift_d[0];
`ifdef FSM_SERIALDATA_TX_PARITY_EN
            S_PARITY: out_d = parity_d ^ (ODD_PARITY != 0);
`endif
            default:  out_d = 1'b1;
        endcase
    end

    assign out_o = out_q;

endmodule

// File: tb/tb_fsm_serialdata_tx.sv
module tb_fsm_serialdata_tx;

    logic       clk;
    logic       reset;
    logic [7:0] in_byte;
    logic       in_valid;
    int         sel;

    logic va, vb, vc;
    logic ra, rb, rc, oa, ob, oc, ba, bb, bc, da, db, dc;
    logic r_s, o_s, b_s, d_s;

    int total = 0;
    int bad   = 0;

`ifdef FSM_SERIALDATA_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    assign va = in_valid && (sel == 0);
    assign vb = in_valid && (sel == 1);
    assign vc = in_valid && (sel == 2);

    fsm_serialdata_tx #(.CLKS_PER_BIT(1), .STOP_BITS(1), .ODD_PARITY(0)) u_a (
        .clk(clk), .reset(reset), .in_byte_i(in_byte), .in_valid_i(va),
        .in_ready_o(ra), .out_o(oa), .busy_o(ba), .done_o(da));
    fsm_serialdata_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1), .ODD_PARITY(0)) u_b (
        .clk(clk), .reset(reset), .in_byte_i(in_byte), .in_valid_i(vb),
        .in_ready_o(rb), .out_o(ob), .busy_o(bb), .done_o(db));
    fsm_serialdata_tx #(.CLKS_PER_BIT(2), .STOP_BITS(2), .ODD_PARITY(1)) u_c (
        .clk(clk), .reset(reset), .in_byte_i(in_byte), .in_valid_i(vc),
        .in_ready_o(rc), .out_o(oc), .busy_o(bc), .done_o(dc));

    always_comb begin
        case (sel)
            1:       begin r_s = rb; o_s = ob; b_s = bb; d_s = db; end
            2:       begin r_s = rc; o_s = oc; b_s = bc; d_s = dc; end
            default: begin r_s = ra; o_s = oa; b_s = ba; d_s = da; end
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         sel;
        logic [7:0] data;
        logic [9:0] exp_frame;   // {stop, D7..D0, start}; bit 0 goes out first
        bit         chain;       // next record is sent back-to-back
        bit         poke;        // raise in_valid mid-frame with a different byte
    } vec_t;

    vec_t tbl[8];
    vec_t rec81;

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, " out"},   o_s, 1'b1);
        chk({tag, " busy"},  b_s, 1'b0);
        chk({tag, " done"},  d_s, 1'b0);
        chk({tag, " ready"}, r_s, 1'b1);
    endtask

    // Called just before the accepting posedge with in_valid/in_byte driven.
    // The task returns at the negedge of the final stop cycle.
    task automatic tx(input vec_t v, input logic [7:0] nb);
        int cpb, stops, flen;
        logic odd;
        logic [11:0] bits;
        case (v.sel)
            1:       begin cpb = 4; stops = 1; odd = 1'b0; end
            2:       begin cpb = 2; stops = 2; odd = 1'b1; end
            default: begin cpb = 1; stops = 1; odd = 1'b0; end
        endcase
        bits = '1;
        bits[9:0] = v.exp_frame;
        if (P == 1) bits[9] = (^v.exp_frame[8:1]) ^ odd;
        flen = (9 + P + stops) * cpb;
        @(posedge clk);
        for (int c = 0; c < flen; c++) begin
            @(negedge clk);
            if (c == 0) in_valid = 1'b0;
            if (v.poke && c == 3) begin in_valid = 1'b1; in_byte = ~v.data; end
            if (v.poke && c == 5) in_valid = 1'b0;
            chk($sformatf("s%0d %h c%0d out", v.sel, v.data, c), o_s, bits[c / cpb]);
            chk($sformatf("s%0d %h c%0d busy", v.sel, v.data, c), b_s, 1'b1);
            chk($sformatf("s%0d %h c%0d done", v.sel, v.data, c), d_s, c == flen - 1);
            chk($sformatf("s%0d %h c%0d ready", v.sel, v.data, c), r_s, c == flen - 1);
            if (c == flen - 1 && v.chain) begin
                in_valid = 1'b1;
                in_byte  = nb;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{0, 8'hA5, 10'b1_10100101_0, 1'b0, 1'b0};
        tbl[1] = '{0, 8'h00, 10'b1_00000000_0, 1'b1, 1'b0};
        tbl[2] = '{0, 8'hFF, 10'b1_11111111_0, 1'b0, 1'b0};
        tbl[3] = '{0, 8'h5A, 10'b1_01011010_0, 1'b0, 1'b1};
        tbl[4] = '{1, 8'h3C, 10'b1_00111100_0, 1'b0, 1'b0};
        tbl[5] = '{1, 8'hC3, 10'b1_11000011_0, 1'b0, 1'b1};
        tbl[6] = '{2, 8'h01, 10'b1_00000001_0, 1'b1, 1'b0};
        tbl[7] = '{2, 8'h80, 10'b1_10000000_0, 1'b0, 1'b0};
        rec81  = '{0, 8'h81, 10'b1_10000001_0, 1'b0, 1'b0};

        reset = 1'b1; in_valid = 1'b0; in_byte = 8'h00; sel = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        idle_chk("reset");
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            idle_chk("idle no valid");
        end

        for (int i = 0; i < 8; i++) begin
            if (i == 0 || !tbl[i-1].chain) begin
                @(negedge clk);
                sel = tbl[i].sel;
                #1;
                chk($sformatf("pre %0d ready", i), r_s, 1'b1);
                in_byte  = tbl[i].data;
                in_valid = 1'b1;
            end
            tx(tbl[i], (i < 7) ? tbl[i+1].data : 8'h00);
            if (!tbl[i].chain) begin
                @(negedge clk);
                idle_chk($sformatf("post %0d", i));
            end
        end

        // Reset in the middle of a frame: out is 1 on the next cycle and the frame is dropped.
        @(negedge clk);
        sel = 0;
        #1;
        in_byte = 8'hC3; in_valid = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 0) in_valid = 1'b0;
            chk($sformatf("abort c%0d done", c), d_s, 1'b0);
            chk($sformatf("abort c%0d busy", c), b_s, 1'b1);
        end
        chk("abort D3 out", o_s, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        idle_chk("after reset");
        reset = 1'b0;
        @(negedge clk);
        idle_chk("after reset 2");
        in_byte = 8'h81; in_valid = 1'b1;
        tx(rec81, 8'h00);
        @(negedge clk);
        idle_chk("post 81");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
